ppr_topk_select: RTL and testbench

- Downstream consumer of the random-walk / score-accumulation stage.
- After the score table in BRAM is final, scans it once and keeps a sorted list of the TOP_K highest-scoring nodes (the PPR result).
- Streams the list out in rank order over a valid/ready interface.
- Owns the BRAM port only while busy; it never writes, so the write enable is tied low.

---
 rtl/ppr_topk_select.sv | 214 +++++++++++++++++++++
 tb/tb_ppr_topk_select.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppr_topk_select.sv
// ppr_topk_select: single-pass top-K selector over the PPR score table.
// Reads scores for nodes 1..NODE_NUM from BRAM, one address per cycle. It keeps a
// sorted list of the TOP_K highest nonzero scores. It then streams the list out
// in rank order over a valid/ready handshake.
// Optional build macro PPR_TOPK_THRESHOLD_EN adds i_min_score. This input is a
// minimum score that is sampled when a start is accepted.
module ppr_topk_select #(
    parameter int ADDR_WIDTH         = 13,
    parameter int DATA_WIDTH         = 32,
    parameter int NODE_NUM           = 100,
    parameter int SCORE_TABLE_OFFSET = 100,
    parameter int TOP_K              = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
`ifdef PPR_TOPK_THRESHOLD_EN
    input  logic [DATA_WIDTH-1:0] i_min_score,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_rank_valid,
    input  logic                  i_rank_ready,
    output logic [3:0]            o_rank_idx,
    output logic [DATA_WIDTH-1:0] o_rank_node,
    output logic [DATA_WIDTH-1:0] o_rank_score
);

    localparam int CNT_W = $clog2(NODE_NUM + 1);
    localparam int IDX_W = (TOP_K > 1) ? $clog2(TOP_K) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        node_cnt_q, node_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rd_vld_q, rd_vld_d;
    logic [CNT_W-1:0]        rd_node_q, rd_node_d;
    logic [3:0]              ptr_q, ptr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [TOP_K-1:0]        ent_vld_q, ent_vld_d;
    logic [DATA_WIDTH-1:0]   ent_node_q  [TOP_K];
    logic [DATA_WIDTH-1:0]   ent_node_d  [TOP_K];
    logic [DATA_WIDTH-1:0]   ent_score_q [TOP_K];
    logic [DATA_WIDTH-1:0]   ent_score_d [TOP_K];

    // Threshold applied to incoming scores. The default build accepts every nonzero score.
    logic [DATA_WIDTH-1:0]   thr;
`ifdef PPR_TOPK_THRESHOLD_EN
    logic [DATA_WIDTH-1:0]   thr_q, thr_d;
    assign thr = thr_q;
`else
    assign thr = DATA_WIDTH'(1);
`endif

    // Insertion network: the list is always sorted, with invalid entries at the tail.
    // Because of that, "new score beats entry" is monotone across positions. The first
    // beaten slot takes the new entry, and every later slot takes its upper neighbour.
    logic                    ins_en;
    logic [DATA_WIDTH-1:0]   new_node;
    logic [TOP_K-1:0]        beats;
    logic [TOP_K-1:0]        ins_vld;
    logic [DATA_WIDTH-1:0]   ins_node  [TOP_K];
    logic [DATA_WIDTH-1:0]   ins_score [TOP_K];

    assign ins_en   = rd_vld_q && (i_mem_data != '0) && (i_mem_data >= thr);
    assign new_node = DATA_WIDTH'(rd_node_q);

    for (genvar gi = 0; gi < TOP_K; gi++) begin : g_slot
        // Strictly greater only, so on a tie the earlier (lower-id) node stays above.
        assign beats[gi] = !ent_vld_q[gi] || (ent_score_q[gi] < i_mem_data);
        if (gi == 0) begin : g_head
            assign ins_vld[gi]   = beats[gi] ? 1'b1       : ent_vld_q[gi];
            assign ins_node[gi]  = beats[gi] ? new_node   : ent_node_q[gi];
            assign ins_score[gi] = beats[gi] ? i_mem_data : ent_score_q[gi];
        end else begin : g_tail
            assign ins_vld[gi]   = beats[gi-1] ? ent_vld_q[gi-1]   :
                                   beats[gi]   ? 1'b1              : ent_vld_q[gi];
            assign ins_node[gi]  = beats[gi-1] ? ent_node_q[gi-1]  :
                                   beats[gi]   ? new_node          : ent_node_q[gi];
            assign ins_score[gi] = beats[gi-1] ? ent_score_q[gi-1] :
                                   beats[gi]   ? i_mem_data        : ent_score_q[gi];
        end
    end

    logic [IDX_W-1:0] ptr_idx;
    assign ptr_idx = ptr_q[IDX_W-1:0];

    // Next-state logic: scan sequencing, read-tag pipeline, list update and drain handshake.
    always_comb begin
        state_d     = state_q;
        node_cnt_d  = node_cnt_q;
        addr_d      = addr_q;
        rd_vld_d    = (state_q == S_SCAN);
        rd_node_d   = node_cnt_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef PPR_TOPK_THRESHOLD_EN
        thr_d       = thr_q;
`endif
        ent_vld_d   = ent_vld_q;
        ent_node_d  = ent_node_q;
        ent_score_d = ent_score_q;

        if (ins_en) begin
            ent_vld_d   = ins_vld;
            ent_node_d  = ins_node;
            ent_score_d = ins_score;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_SCAN;
                    node_cnt_d = CNT_W'(1);
                    addr_d     = ADDR_WIDTH'(SCORE_TABLE_OFFSET + 1);
                    busy_d     = 1'b1;
`ifdef PPR_TOPK_THRESHOLD_EN
                    thr_d      = i_min_score;
`endif
                    ent_vld_d  = '0;
                    for (int i = 0; i < TOP_K; i++) begin
                        ent_node_d[i]  = '0;
                        ent_score_d[i] = '0;
                    end
                end
            end
            S_SCAN: begin
                if (node_cnt_q == CNT_W'(NODE_NUM)) begin
                    state_d = S_FLUSH;
                    addr_d  = '0;
                end else begin
                    node_cnt_d = node_cnt_q + CNT_W'(1);
                    addr_d     = ADDR_WIDTH'(SCORE_TABLE_OFFSET) +
                                 ADDR_WIDTH'(node_cnt_q + CNT_W'(1));
                end
            end
            S_FLUSH: begin
                state_d = S_DRAIN;
                ptr_d   = '0;
            end
            S_DRAIN: begin
                if (!ent_vld_q[ptr_idx] ||
                    (i_rank_ready && (ptr_q == 4'(TOP_K - 1)))) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ptr_d   = '0;
                end else if (i_rank_ready) begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset. Reset aborts any scan or drain.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            node_cnt_q <= '0;
            addr_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_node_q  <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PPR_TOPK_THRESHOLD_EN
            thr_q      <= '0;
`endif
            ent_vld_q  <= '0;
            for (int i = 0; i < TOP_K; i++) begin
                ent_node_q[i]  <= '0;
                ent_score_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            node_cnt_q  <= node_cnt_d;
            addr_q      <= addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_node_q   <= rd_node_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PPR_TOPK_THRESHOLD_EN
            thr_q       <= thr_d;
`endif
            ent_vld_q   <= ent_vld_d;
            ent_node_q  <= ent_node_d;
            ent_score_q <= ent_score_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_we     = 1'b0;
    assign o_rank_valid = (state_q == S_DRAIN) && ent_vld_q[ptr_idx];
    assign o_rank_idx   = (state_q == S_DRAIN) ? ptr_q : 4'd0;
    assign o_rank_node  = (state_q == S_DRAIN) ? ent_node_q[ptr_idx]  : '0;
    assign o_rank_score = (state_q == S_DRAIN) ? ent_score_q[ptr_idx] : '0;

endmodule

// File: tb/tb_ppr_topk_select.sv
// Testbench for ppr_topk_select. It uses a small instance (TOP_K=4, NODE_NUM=8) and a
// large instance (TOP_K=8, NODE_NUM=100). Both share one BRAM model with registered reads.
`timescale 1ns/1ps
module tb_ppr_topk_select;

    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int OFF = 100;
    localparam int N_A = 8;
    localparam int K_A = 4;
    localparam int N_B = 100;
    localparam int K_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, ready, sel;
    logic [DW-1:0] min_score;
    logic          a_start, b_start;
    assign a_start = start & ~sel;
    assign b_start = start & sel;

    logic          a_busy, a_done, a_we, a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data, a_node, a_score;
    logic [3:0]    a_idx;
    logic          b_busy, b_done, b_we, b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data, b_node, b_score;
    logic [3:0]    b_idx;

    ppr_topk_select #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NODE_NUM(N_A),
                      .SCORE_TABLE_OFFSET(OFF), .TOP_K(K_A)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start),
`ifdef PPR_TOPK_THRESHOLD_EN
        .i_min_score(min_score),
`endif
        .o_busy(a_busy), .o_done(a_done), .o_mem_addr(a_addr), .o_mem_we(a_we),
        .i_mem_data(a_data), .o_rank_valid(a_valid), .i_rank_ready(ready),
        .o_rank_idx(a_idx), .o_rank_node(a_node), .o_rank_score(a_score)
    );

    ppr_topk_select #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NODE_NUM(N_B),
                      .SCORE_TABLE_OFFSET(OFF), .TOP_K(K_B)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start),
`ifdef PPR_TOPK_THRESHOLD_EN
        .i_min_score(min_score),
`endif
        .o_busy(b_busy), .o_done(b_done), .o_mem_addr(b_addr), .o_mem_we(b_we),
        .i_mem_data(b_data), .o_rank_valid(b_valid), .i_rank_ready(ready),
        .o_rank_idx(b_idx), .o_rank_node(b_node), .o_rank_score(b_score)
    );

    // Score table with one-cycle read latency
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        a_data <= mem[a_addr[7:0]];
        b_data <= mem[b_addr[7:0]];
    end

    // Signals of the instance under test
    logic          cur_busy, cur_done, cur_we, cur_valid;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_node, cur_score;
    logic [3:0]    cur_idx;
    assign cur_busy  = sel ? b_busy  : a_busy;
    assign cur_done  = sel ? b_done  : a_done;
    assign cur_we    = sel ? b_we    : a_we;
    assign cur_valid = sel ? b_valid : a_valid;
    assign cur_addr  = sel ? b_addr  : a_addr;
    assign cur_idx   = sel ? b_idx   : a_idx;
    assign cur_node  = sel ? b_node  : a_node;
    assign cur_score = sel ? b_score : a_score;

    typedef struct {
        int idx;
        int node;
        int score;
    } rank_t;
    rank_t exp_q[$];

    int n_assert      = 0;
    int n_fail        = 0;
    int cyc           = 0;
    int last_xfer_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference ranking: repeated max-selection, with the lowest id winning ties
    task automatic push_expected(input int n, input int k, input int unsigned thr);
        bit    used [0:255];
        rank_t r;
        for (int i = 0; i < 256; i++) used[i] = 1'b0;
        for (int rk = 0; rk < k; rk++) begin
            int best = 0;
            for (int id = 1; id <= n; id++) begin
                if (!used[id] && mem[OFF+id] != 0 && mem[OFF+id] >= thr &&
                    (best == 0 || mem[OFF+id] > mem[OFF+best]))
                    best = id;
            end
            if (best == 0) break;
            used[best] = 1'b1;
            r.idx   = rk;
            r.node  = best;
            r.score = int'(mem[OFF+best]);
            exp_q.push_back(r);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks that stalled outputs hold
    logic          stall_p = 1'b0;
    logic [3:0]    h_idx;
    logic [DW-1:0] h_node, h_score;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                check("stall_valid", 32'(cur_valid), 32'd1);
                check("stall_idx",   32'(cur_idx),   32'(h_idx));
                check("stall_node",  cur_node,       h_node);
                check("stall_score", cur_score,      h_score);
            end
            if (cur_valid && ready) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL rank_unexpected: observed idx %0d node %0d, expected no rank",
                           cur_idx, cur_node);
                end
                if (exp_q.size() != 0) begin
                    rank_t e;
                    e = exp_q.pop_front();
                    check("rank_idx",   32'(cur_idx), e.idx);
                    check("rank_node",  cur_node,     e.node);
                    check("rank_score", cur_score,    e.score);
                end
                last_xfer_cyc = cyc;
            end
            stall_p = cur_valid && !ready;
            h_idx   = cur_idx;
            h_node  = cur_node;
            h_score = cur_score;
        end
    end

    // Runs one scan on the selected instance. It returns the done cycle relative to
    // the accepting edge, and also the absolute done cycle.
    task automatic run_scan(input int n, input bit toggle_ready,
                            output int done_cyc, output int done_abs);
        int         k   = 0;
        logic [3:0] pat = 4'b1001;
        done_cyc = 0;
        done_abs = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (toggle_ready && cur_valid) begin
                ready = pat[k % 4];
                k++;
            end else begin
                ready = 1'b1;
            end
            @(negedge clk);
            if (c == 1) begin
                check("busy_after_start", 32'(cur_busy), 32'd1);
                check("first_addr",       32'(cur_addr), 32'(OFF + 1));
                check("mem_we",           32'(cur_we),   32'd0);
            end
            if (c == n) check("last_addr", 32'(cur_addr), 32'(OFF + n));
            if (cur_done) begin
                done_cyc = c;
                done_abs = cyc;
                check("busy_at_done", 32'(cur_busy), 32'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        check("done_seen", 32'(done_cyc > 0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", 32'(cur_done), 32'd0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic load_basic();
        int unsigned sc [8] = '{5, 0, 9, 3, 9, 1, 7, 2};
        clear_mem();
        for (int i = 0; i < 8; i++) mem[OFF+1+i] = sc[i];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, da, dn;
        rst_n = 1'b0; start = 1'b0; ready = 1'b1; sel = 1'b0; min_score = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_done",  32'(a_done),  32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_addr",  32'(a_addr),  32'd0);
        check("rst_idx",   32'(a_idx),   32'd0);
        check("rst_node",  a_node,       32'd0);
        check("rst_score", a_score,      32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mixed scores with a tie at 9, ready held high
        load_basic();
        push_expected(N_A, K_A, 1);
        run_scan(N_A, 1'b0, dc, da);
        check("t1_done_cycle",     32'(dc),                 32'(N_A + 2 + K_A));
        check("t1_done_after_xfr", 32'(da - last_xfer_cyc), 32'd1);
        check("t1_sb_empty",       32'(exp_q.size()),       32'd0);

        // All scores zero: no ranks, done at NODE_NUM+3
        clear_mem();
        run_scan(N_A, 1'b0, dc, da);
        check("t2_done_cycle", 32'(dc), 32'(N_A + 3));

        // Single nonzero node
        clear_mem();
        mem[OFF+6] = 42;
        push_expected(N_A, K_A, 1);
        run_scan(N_A, 1'b0, dc, da);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure pattern 1,0,0,1 during drain
        load_basic();
        push_expected(N_A, K_A, 1);
        run_scan(N_A, 1'b1, dc, da);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Large instance: reset in cycle 50 of the scan, then a clean rescan
        sel = 1'b1;
        clear_mem();
        for (int id = 1; id <= N_B; id++)
            mem[OFF+id] = (id <= 49) ? DW'(1000 + id) : DW'((id % 7) * 3);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (49) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_busy_after_rst",  32'(b_busy),  32'd0);
        check("t5_valid_after_rst", 32'(b_valid), 32'd0);
        check("t5_addr_after_rst",  32'(b_addr),  32'd0);
        dn = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (b_done || b_valid) dn++;
        end
        check("t5_no_done_or_valid", 32'(dn), 32'd0);
        clear_mem();
        for (int id = 50; id <= N_B; id++) mem[OFF+id] = DW'((id * 13) % 29);
        push_expected(N_B, K_B, 1);
        @(posedge clk);
        #1;
        run_scan(N_B, 1'b0, dc, da);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        sel = 1'b0;

`ifdef PPR_TOPK_THRESHOLD_EN
        // Minimum score 6 removes the rank with score 5
        load_basic();
        min_score = 6;
        push_expected(N_A, K_A, 6);
        @(posedge clk);
        #1;
        run_scan(N_A, 1'b0, dc, da);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        min_score = '0;
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
